// File: rtl/global_buffer_param.sv
// Shared global-buffer widths, the parallel-config FSM encoding and the bank word stride.
package global_buffer_param;
  localparam int GLB_ADDR_WIDTH   = 22;
  localparam int BANK_DATA_WIDTH  = 64;
  localparam int CGRA_CFG_WIDTH   = 32;
  localparam int CNT_WIDTH        = 20;
  localparam int PCFG_BYTE_STRIDE = 8;

  typedef enum logic [1:0] {
    PCFG_IDLE = 2'd0,
    PCFG_RUN  = 2'd1,
    PCFG_DONE = 2'd2
  } pcfg_state_e;
endpackage

// File: rtl/global_buffer_pkg.sv
// Global-buffer structured types built on the shared widths.
package global_buffer_pkg;
  import global_buffer_param::*;

  typedef struct packed {
    logic                      wr_en;
    logic [CGRA_CFG_WIDTH-1:0] addr;
    logic [CGRA_CFG_WIDTH-1:0] data;
  } cgra_cfg_t;
endpackage

// File: rtl/glb_pcfg_addr_gen.sv
// Request side of the pcfg DMA: latches the aligned start address and issues one
// 8-byte read per cycle until the latched word count has been requested.
module glb_pcfg_addr_gen #(
  parameter int GLB_ADDR_WIDTH = global_buffer_param::GLB_ADDR_WIDTH,
  parameter int CNT_WIDTH      = global_buffer_param::CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_i,
  input  logic                      run_i,
  input  logic [GLB_ADDR_WIDTH-1:0] start_addr_i,
  input  logic [CNT_WIDTH-1:0]      num_cfg_i,
  output logic                      rd_req_en_o,
  output logic [GLB_ADDR_WIDTH-1:0] rd_req_addr_o
);
  import global_buffer_param::PCFG_BYTE_STRIDE;

  localparam logic [GLB_ADDR_WIDTH-1:0] STRIDE = GLB_ADDR_WIDTH'(PCFG_BYTE_STRIDE);

  logic [GLB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]      iss_q, iss_d;

  assign rd_req_en_o   = run_i && (iss_q < num_cfg_i);
  assign rd_req_addr_o = addr_q;

  // The address adder simply rolls over, giving the modulo-2^GLB_ADDR_WIDTH wrap.
  always_comb begin
    addr_d = addr_q;
    iss_d  = iss_q;
    if (start_i) begin
      addr_d = start_addr_i & ~(STRIDE - GLB_ADDR_WIDTH'(1));
      iss_d  = '0;
    end else if (rd_req_en_o) begin
      addr_d = addr_q + STRIDE;
      iss_d  = iss_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      iss_q  <= '0;
    end else begin
      addr_q <= addr_d;
      iss_q  <= iss_d;
    end
  end
endmodule

// File: rtl/glb_core_pcfg_dma.sv
// Parallel-configuration DMA: streams 64-bit bitstream words from bank memory into
// CGRA config writes. Optional cycle counter is built when GLB_PCFG_PERF_EN is defined.
module glb_core_pcfg_dma #(
  parameter int GLB_ADDR_WIDTH  = global_buffer_param::GLB_ADDR_WIDTH,
  parameter int BANK_DATA_WIDTH = global_buffer_param::BANK_DATA_WIDTH,
  parameter int CNT_WIDTH       = global_buffer_param::CNT_WIDTH,
  parameter int CGRA_CFG_WIDTH  = global_buffer_param::CGRA_CFG_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [GLB_ADDR_WIDTH-1:0]  cfg_pcfg_start_addr,
  input  logic [CNT_WIDTH-1:0]       cfg_pcfg_num_cfg,
  input  logic                       pcfg_start_pulse,
  output logic                       rd_req_en,
  output logic [GLB_ADDR_WIDTH-1:0]  rd_req_addr,
  input  logic                       rd_res_valid,
  input  logic [BANK_DATA_WIDTH-1:0] rd_res_data,
  output logic                       cgra_cfg_wr_en,
  output logic [CGRA_CFG_WIDTH-1:0]  cgra_cfg_addr,
  output logic [CGRA_CFG_WIDTH-1:0]  cgra_cfg_data,
  output logic                       pcfg_busy,
  output logic                       pcfg_done_pulse,
  output logic [31:0]                pcfg_cycle_cnt
);
  import global_buffer_param::pcfg_state_e;
  import global_buffer_param::PCFG_IDLE;
  import global_buffer_param::PCFG_RUN;
  import global_buffer_param::PCFG_DONE;
  import global_buffer_pkg::cgra_cfg_t;

  pcfg_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [CNT_WIDTH-1:0] rcv_q, rcv_d;
  cgra_cfg_t            cfg_q, cfg_d;

  logic accept, res_fire, last_rcv;

  assign accept   = (state_q == PCFG_IDLE) && pcfg_start_pulse;
  assign res_fire = (state_q == PCFG_RUN) && rd_res_valid;
  // In RUN num_q is non-zero, so rcv_q + 1 never overflows the counter width.
  assign last_rcv = res_fire && ((rcv_q + CNT_WIDTH'(1)) == num_q);

  glb_pcfg_addr_gen #(
    .GLB_ADDR_WIDTH(GLB_ADDR_WIDTH),
    .CNT_WIDTH     (CNT_WIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .start_i      (accept),
    .run_i        (state_q == PCFG_RUN),
    .start_addr_i (cfg_pcfg_start_addr),
    .num_cfg_i    (num_q),
    .rd_req_en_o  (rd_req_en),
    .rd_req_addr_o(rd_req_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PCFG_IDLE;
      num_q   <= '0;
      rcv_q   <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rcv_q   <= rcv_d;
      cfg_q   <= cfg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PCFG_IDLE: if (accept) state_d = (cfg_pcfg_num_cfg == '0) ? PCFG_DONE : PCFG_RUN;
      PCFG_RUN:  if (last_rcv) state_d = PCFG_DONE;
      PCFG_DONE: state_d = PCFG_IDLE;
      default:   state_d = PCFG_IDLE;
    endcase
  end

  always_comb begin
    num_d       = num_q;
    rcv_d       = rcv_q;
    cfg_d       = cfg_q;
    cfg_d.wr_en = res_fire;
    if (accept) begin
      num_d = cfg_pcfg_num_cfg;
      rcv_d = '0;
    end
    if (res_fire) begin
      rcv_d      = rcv_q + CNT_WIDTH'(1);
      cfg_d.addr = rd_res_data[63:32];
      cfg_d.data = rd_res_data[31:0];
    end
  end

  always_comb begin
    pcfg_busy       = (state_q != PCFG_IDLE);
    pcfg_done_pulse = (state_q == PCFG_DONE);
    cgra_cfg_wr_en  = cfg_q.wr_en;
    cgra_cfg_addr   = cfg_q.addr;
    cgra_cfg_data   = cfg_q.data;
  end

`ifdef GLB_PCFG_PERF_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (accept) cyc_d = '0;
    else if ((state_q != PCFG_IDLE) && (cyc_q != 32'hFFFF_FFFF)) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign pcfg_cycle_cnt = cyc_q;
`else
  assign pcfg_cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_glb_core_pcfg_dma.sv
// Scoreboard bench for glb_core_pcfg_dma: a latency-randomised memory responder feeds
// queued responses; expected requests/writes/done/busy come from a cycle model.
module tb_glb_core_pcfg_dma;
  localparam int AW = 22;
  localparam int DW = 64;
  localparam int CW = 20;
  localparam int FW = 32;
`ifdef GLB_PCFG_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cfg_pcfg_start_addr;
  logic [CW-1:0] cfg_pcfg_num_cfg;
  logic          pcfg_start_pulse;
  logic          rd_req_en;
  logic [AW-1:0] rd_req_addr;
  logic          rd_res_valid;
  logic [DW-1:0] rd_res_data;
  logic          cgra_cfg_wr_en;
  logic [FW-1:0] cgra_cfg_addr;
  logic [FW-1:0] cgra_cfg_data;
  logic          pcfg_busy;
  logic          pcfg_done_pulse;
  logic [31:0]   pcfg_cycle_cnt;

  always #5 clk = ~clk;

  glb_core_pcfg_dma #(
    .GLB_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DW), .CNT_WIDTH(CW), .CGRA_CFG_WIDTH(FW)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_pcfg_start_addr(cfg_pcfg_start_addr), .cfg_pcfg_num_cfg(cfg_pcfg_num_cfg),
    .pcfg_start_pulse(pcfg_start_pulse),
    .rd_req_en(rd_req_en), .rd_req_addr(rd_req_addr),
    .rd_res_valid(rd_res_valid), .rd_res_data(rd_res_data),
    .cgra_cfg_wr_en(cgra_cfg_wr_en), .cgra_cfg_addr(cgra_cfg_addr), .cgra_cfg_data(cgra_cfg_data),
    .pcfg_busy(pcfg_busy), .pcfg_done_pulse(pcfg_done_pulse), .pcfg_cycle_cnt(pcfg_cycle_cnt)
  );

  typedef struct {
    int          due;
    logic [63:0] data;
    bit          live;
  } resp_t;

  resp_t         resp_q[$];
  logic [AW-1:0] exp_req_q[$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit start_req = 0, rst_req = 0;
  int lat_min = 1, lat_max = 1, last_due = 0;
  // Expectations for the cycle sampled on the next tick.
  bit          e_busy = 0, e_done = 0, e_wr = 0;
  logic [63:0] e_wr_data = '0;
  logic [31:0] e_cnt = '0;
  int m_num = 0, live_sent = 0;
  int n_req, n_wr, n_done, first_req_cyc, done_cyc, start_cyc, last_resp_cyc;
  logic [31:0] first_wr_addr, first_wr_data;

  function automatic logic [63:0] memf(input logic [AW-1:0] a);
    logic [31:0] a32;
    a32 = 32'(a);
    return {a32 >> 4, 32'hDEAD_BEEF ^ a32 ^ 32'h0000_0100};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    n_req = 0; n_wr = 0; n_done = 0;
    first_req_cyc = -1; done_cyc = -1; last_resp_cyc = -1;
    first_wr_addr = '0; first_wr_data = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_en"},   rd_req_en,       0);
    chk({tag, "_req_addr"}, rd_req_addr,     0);
    chk({tag, "_wr_en"},    cgra_cfg_wr_en,  0);
    chk({tag, "_cfg_addr"}, cgra_cfg_addr,   0);
    chk({tag, "_cfg_data"}, cgra_cfg_data,   0);
    chk({tag, "_busy"},     pcfg_busy,       0);
    chk({tag, "_done"},     pcfg_done_pulse, 0);
    chk({tag, "_cyc_cnt"},  pcfg_cycle_cnt,  0);
  endtask

  task automatic tick();
    resp_t         r;
    bit            accept, nb_done, nb_wr;
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    cyc++;
    chk("busy", pcfg_busy, e_busy);
    chk("done", pcfg_done_pulse, e_done);
    chk("wr_en", cgra_cfg_wr_en, e_wr);
    if (e_wr && cgra_cfg_wr_en) begin
      chk("wr_addr", cgra_cfg_addr, e_wr_data[63:32]);
      chk("wr_data", cgra_cfg_data, e_wr_data[31:0]);
    end
    chk("cycle_cnt", pcfg_cycle_cnt, PERF ? e_cnt : 32'd0);
    if (cgra_cfg_wr_en) begin
      if (n_wr == 0) begin
        first_wr_addr = cgra_cfg_addr;
        first_wr_data = cgra_cfg_data;
      end
      n_wr++;
    end
    if (pcfg_done_pulse) begin
      n_done++;
      done_cyc = cyc;
    end
    if (rd_req_en) begin
      if (n_req == 0) first_req_cyc = cyc;
      n_req++;
      if (exp_req_q.size() == 0) chk("req_extra", 1, 0);
      else chk("req_addr", rd_req_addr, exp_req_q.pop_front());
      r.due = cyc + int'($urandom_range(lat_max, lat_min));
      if (r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      r.data = memf(rd_req_addr);
      r.live = !rst_req;
      resp_q.push_back(r);
    end

    reset            = rst_req;
    pcfg_start_pulse = start_req;
    accept  = start_req && !e_busy && !rst_req;
    nb_done = 0;
    nb_wr   = 0;
    rd_res_valid = 1'b0;
    rd_res_data  = '0;
    if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
      r = resp_q.pop_front();
      rd_res_valid = 1'b1;
      rd_res_data  = r.data;
      if (r.live && !rst_req) begin
        nb_wr = 1;
        e_wr_data = r.data;
        live_sent++;
        last_resp_cyc = cyc;
        if (live_sent == m_num) nb_done = 1;
      end
    end
    if (accept) begin
      m_num = int'(cfg_pcfg_num_cfg);
      live_sent = 0;
      a = cfg_pcfg_start_addr & ~AW'(7);
      for (int k = 0; k < m_num; k++) begin
        exp_req_q.push_back(a);
        a = a + AW'(8);
      end
      if (m_num == 0) nb_done = 1;
    end
    if (rst_req) begin
      e_cnt = '0;
      e_busy = 0;
      exp_req_q.delete();
      foreach (resp_q[i]) resp_q[i].live = 0;
    end else begin
      if (accept) e_cnt = '0;
      else if (e_busy && e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 32'd1;
      e_busy = accept ? 1'b1 : (e_done ? 1'b0 : e_busy);
    end
    e_done = nb_done;
    e_wr   = nb_wr;
    start_req = 0;
    rst_req   = 0;
  endtask

  task automatic wait_done(input int budget);
    int i;
    i = 0;
    while (n_done == 0 && i < budget) begin
      tick();
      i++;
    end
    if (n_done == 0) chk("timeout_done", 0, 1);
    tick();
  endtask

  task automatic run_xfer(input logic [AW-1:0] addr, input int num, input int lmin,
                          input int lmax, input int budget);
    clr_stats();
    cfg_pcfg_start_addr = addr;
    cfg_pcfg_num_cfg    = CW'(num);
    lat_min = lmin;
    lat_max = lmax;
    start_req = 1;
    start_cyc = cyc + 1;
    tick();
    wait_done(budget);
  endtask

  initial begin
    int nw;
    reset = 1'b1;
    pcfg_start_pulse = 1'b0;
    rd_res_valid = 1'b0;
    rd_res_data = '0;
    cfg_pcfg_start_addr = '0;
    cfg_pcfg_num_cfg = '0;
    clr_stats();
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    tick();
    tick();

    run_xfer(AW'('h100), 4, 3, 3, 100);
    chk("t1_nreq", n_req, 4);
    chk("t1_first_req_lat", first_req_cyc - start_cyc, 1);
    chk("t1_done_lat", done_cyc - start_cyc, 8);
    chk("t1_nwr", n_wr, 4);
    chk("t1_wr0_addr", first_wr_addr, 32'h0000_0010);
    chk("t1_wr0_data", first_wr_data, 32'hDEAD_BEEF);
    chk("t1_ndone", n_done, 1);

    run_xfer(AW'('h200), 0, 1, 1, 20);
    chk("t2_nreq", n_req, 0);
    chk("t2_done_lat", done_cyc - start_cyc, 1);
    chk("t2_ndone", n_done, 1);
    chk("t2_cyc_cnt", pcfg_cycle_cnt, PERF ? 32'd1 : 32'd0);

    run_xfer(AW'('h3F_FFF8), 3, 2, 4, 100);
    chk("t3_nreq", n_req, 3);
    chk("t3_nwr", n_wr, 3);

    // Second start two cycles into a transfer, with new cfg values, must be dropped.
    clr_stats();
    cfg_pcfg_start_addr = AW'('h2000);
    cfg_pcfg_num_cfg = CW'(5);
    lat_min = 1; lat_max = 4;
    start_req = 1;
    start_cyc = cyc + 1;
    tick();
    tick();
    cfg_pcfg_start_addr = AW'('h3000);
    cfg_pcfg_num_cfg = CW'(9);
    start_req = 1;
    tick();
    wait_done(200);
    repeat (12) tick();
    chk("t4_nreq", n_req, 5);
    chk("t4_nwr", n_wr, 5);
    chk("t4_ndone", n_done, 1);

    // Reset after two of six writes; in-flight responses must be ignored.
    clr_stats();
    cfg_pcfg_start_addr = AW'('h400);
    cfg_pcfg_num_cfg = CW'(6);
    lat_min = 3; lat_max = 3;
    start_req = 1;
    tick();
    for (int i = 0; i < 50 && n_wr < 2; i++) tick();
    chk("t5_two_writes", n_wr, 2);
    rst_req = 1;
    tick();
    tick();
    chk_idle_outputs("t5_after_rst");
    nw = n_wr;
    repeat (12) tick();
    chk("t5_no_late_writes", n_wr, nw);
    chk("t5_drained", resp_q.size(), 0);
    run_xfer(AW'('h40), 2, 1, 3, 100);
    chk("t5_restart_nwr", n_wr, 2);
    chk("t5_restart_ndone", n_done, 1);

    run_xfer(AW'('h1000), 64, 1, 10, 2000);
    chk("t6_nreq", n_req, 64);
    chk("t6_nwr", n_wr, 64);
    chk("t6_done_after_last", done_cyc - last_resp_cyc, 1);
    chk("t6_ndone", n_done, 1);
    chk("t6_req_q_empty", exp_req_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/glb_core_pcfg_dma.md
# glb_core_pcfg_dma

Parallel-configuration DMA for one global buffer tile. On a start pulse it streams a bitstream of configuration words out of the tile's bank memory. It unpacks each 64-bit word into one CGRA configuration write (address, data). It signals completion with a one-cycle done pulse. It is the producer side of the tile's parallel-configuration path: its read requests and responses form the traffic the tile switch hands to, and receives from, the parallel-configuration router.

## Interface
- GLB_ADDR_WIDTH, 22, byte address width of bank memory
- BANK_DATA_WIDTH, 64, read data width (fixed at 64; other values unsupported)
- CNT_WIDTH, 20, width of the configuration word count
- CGRA_CFG_WIDTH, 32, CGRA config address and data width each
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- cfg_pcfg_start_addr  input  GLB_ADDR_WIDTH  bitstream start byte address; bits [2:0] ignored
- cfg_pcfg_num_cfg  input  CNT_WIDTH  number of 64-bit config words
- pcfg_start_pulse  input  1  start request, one cycle
- rd_req_en  output  1  read request valid
- rd_req_addr  output  GLB_ADDR_WIDTH  read byte address, 8-byte aligned
- rd_res_valid  input  1  read response valid; in order, arbitrary latency ≥1 cycle
- rd_res_data  input  BANK_DATA_WIDTH  read response data
- cgra_cfg_wr_en  output  1  CGRA config write strobe
- cgra_cfg_addr  output  CGRA_CFG_WIDTH  equals rd_res_data[63:32]
- cgra_cfg_data  output  CGRA_CFG_WIDTH  equals rd_res_data[31:0]
- pcfg_busy  output  1  high from the cycle after an accepted start until the done pulse inclusive
- pcfg_done_pulse  output  1  one-cycle completion pulse
- pcfg_cycle_cnt  output  32  cycles spent on the last transfer (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - A start is accepted on pcfg_start_pulse.
  - On acceptance: latch start_addr with bits [2:0] forced to 0, latch num_cfg, clear the issue and receive counters.
  - Next state is RUN if num_cfg≠0; otherwise DONE.
- RUN, request side:
  - While issued < num_cfg, assert rd_req_en every cycle (no request-side backpressure).
  - rd_req_addr starts at the latched start address and increments by 8 per request.
  - The address wraps modulo 2^GLB_ADDR_WIDTH.
- RUN, response side:
  - Every rd_res_valid increments the received count.
  - It also produces one registered CGRA write.
- RUN exit: when received reaches num_cfg, move to DONE.
- DONE: assert pcfg_done_pulse for one cycle, then return to IDLE.
- pcfg_start_pulse in RUN or DONE is ignored; it is not queued.
- rd_res_valid in IDLE or DONE is ignored and produces no write.
- Changes to cfg_* inputs after acceptance have no effect on the running transfer.
- Counters are CNT_WIDTH wide. num_cfg = 2^CNT_WIDTH−1 completes without overflow.
- A response in the same cycle as a request is handled independently of it.

## Timing
- Reset values: rd_req_en=0, rd_req_addr=0, cgra_cfg_wr_en=0, cgra_cfg_addr=0, cgra_cfg_data=0, pcfg_busy=0, pcfg_done_pulse=0, pcfg_cycle_cnt=0, FSM=IDLE.
- Reset asserted mid-transfer returns all state to these values on the next edge. Responses still in flight afterwards are ignored.
- Start at cycle t:
  - First rd_req_en at t+1.
  - Request k (k = 0-based request index) at t+1+k.
  - pcfg_busy rises at t+1.
- rd_res_valid at cycle r gives cgra_cfg_wr_en at r+1. cgra_cfg_wr_en is registered and cleared when no response arrived.
- Last response at cycle r:
  - Last write at r+1.
  - pcfg_done_pulse at r+1.
  - pcfg_busy falls at r+2.
- num_cfg=0 with start at t:
  - pcfg_busy and pcfg_done_pulse both high at t+1, no requests.
  - IDLE at t+2.
- Back-to-back: a start is accepted in the first IDLE cycle after DONE.

## Configuration
- Macro: GLB_PCFG_PERF_EN.
- With the macro defined:
  - A 32-bit counter clears on start acceptance and increments every cycle pcfg_busy is high.
  - It holds its value after done.
  - pcfg_cycle_cnt presents the counter.
  - The counter saturates at 0xFFFF_FFFF.
- Without the macro: no counter is built and pcfg_cycle_cnt is tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Shared package global_buffer_param holds:
  - GLB_ADDR_WIDTH, BANK_DATA_WIDTH, CGRA_CFG_WIDTH, CNT_WIDTH.
  - The pcfg FSM state enum.
  - The byte stride constant (8).
- global_buffer_pkg holds the cgra_cfg_t struct {wr_en, addr, data}.
- One sub-module: glb_pcfg_addr_gen, containing the latched start address, the issue counter, rd_req_en and rd_req_addr generation with wrap.
- The top level holds the FSM, the receive counter, the output register and the perf counter.

## Test plan
- start_addr=0x100, num_cfg=4, response latency 3:
  - Requests 0x100, 0x108, 0x110, 0x118 on t+1..t+4.
  - Response data 0x0000_0010_DEAD_BEEF gives write addr=0x10, data=0xDEADBEEF.
  - Done at t+8.
- num_cfg=0:
  - No rd_req_en.
  - Done and busy at t+1 only.
  - With GLB_PCFG_PERF_EN, pcfg_cycle_cnt=1.
- start_addr=0x3F_FFF8, num_cfg=3: addresses 0x3FFFF8, 0x000000, 0x000008 (wrap).
- Second start pulse two cycles after the first, num_cfg=5: ignored; exactly 5 requests and 5 writes, one done pulse.
- reset asserted after 2 of 6 responses:
  - All outputs 0 next cycle.
  - Late responses produce no writes.
  - A new start with num_cfg=2 completes normally.
- Random response gaps (latency 1–10 cycles), num_cfg=64: 64 writes in request order, matching memory contents; done one cycle after the last response.
